// File: rtl/cfg_const_pkg.sv
// cfg_const_pkg: shared types and sizing helpers for the constant bank.
// Chain length grows by one when CFG_CONST_BANK_PARITY_EN is defined.
package cfg_const_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic int chain_len(
    input int num_ch,
    input int width
  );
`ifdef CFG_CONST_BANK_PARITY_EN
    return num_ch * width + 1;
`else
    return num_ch * width;
`endif
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/cfg_shift_chain.sv
// cfg_shift_chain: serial config shadow register with a registered tail tap.
// Reusable by any block hanging off the configuration scan chain.
module cfg_shift_chain #(
  parameter int   LEN       = 8,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           din,
  output logic [LEN-1:0] q,
  output logic           tail
);

  logic [LEN-1:0] nxt;

  if (LEN == 1) begin : g_one
    assign nxt = din;
  end else begin : g_many
    assign nxt = {q[LEN-2:0], din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= {LEN{RESET_VAL}};
      tail <= RESET_VAL;
    end else begin
      if (en) q <= nxt;
      // tail trails the MSB by one cycle so it can feed the next block
      tail <= q[LEN-1];
    end
  end

endmodule

// File: rtl/cfg_const_bank.sv
// cfg_const_bank: scan-loaded bank of NUM_CH x WIDTH tie-off constants.
// Define CFG_CONST_BANK_PARITY_EN to add an even-parity LSB to the chain.
module cfg_const_bank
  import cfg_const_pkg::*;
#(
  parameter int   NUM_CH    = 4,
  parameter int   WIDTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    config_enable,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic                    commit,
  output logic [NUM_CH*WIDTH-1:0] const_out,
  output logic                    cfg_full,
  output logic                    cfg_err
);

  localparam int N  = NUM_CH * WIDTH;
  localparam int L  = chain_len(NUM_CH, WIDTH);
  localparam int CW = cnt_width(L);
  localparam logic [CW-1:0] LMAX = CW'(L);

  state_t         state;
  logic [CW-1:0]  count;
  logic [L-1:0]   shadow;
  logic [N-1:0]   shadow_data;
  logic           par_ok;
  logic           accept;
  logic           reject;

  cfg_shift_chain #(
    .LEN       (L),
    .RESET_VAL (RESET_VAL)
  ) u_chain (
    .clk  (prog_clk),
    .rst  (pReset),
    .en   (config_enable),
    .din  (ccff_head),
    .q    (shadow),
    .tail (ccff_tail)
  );

`ifdef CFG_CONST_BANK_PARITY_EN
  assign par_ok      = ~^shadow;
  assign shadow_data = shadow[L-1:1];
`else
  assign par_ok      = 1'b1;
  assign shadow_data = shadow;
`endif

  assign accept = commit & ~config_enable
                & (state == FULL) & par_ok;
  assign reject = commit & ~accept;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      count     <= '0;
      cfg_full  <= 1'b0;
      cfg_err   <= 1'b0;
      const_out <= {N{RESET_VAL}};
    end else begin
      if (reject) cfg_err <= 1'b1;
      if (accept) begin
        const_out <= shadow_data;
        count     <= '0;
        state     <= IDLE;
        cfg_full  <= 1'b0;
      end else if (config_enable) begin
        unique case (state)
          IDLE: begin
            count    <= CW'(1);
            state    <= (L == 1) ? FULL : LOAD;
            cfg_full <= (L == 1);
          end
          LOAD: begin
            count <= count + 1'b1;
            if (count == LMAX - 1'b1) begin
              state    <= FULL;
              cfg_full <= 1'b1;
            end
          end
          FULL: count <= LMAX;
          default: begin
            state    <= IDLE;
            count    <= '0;
            cfg_full <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_const_bank.sv
// tb_cfg_const_bank: scoreboard bench with a bit-history reference model.
// Honours CFG_CONST_BANK_PARITY_EN when the build defines it.
module tb_cfg_const_bank;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 2;
  localparam int N      = NUM_CH * WIDTH;
`ifdef CFG_CONST_BANK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int   L  = N + PAR;
  localparam logic RV = 1'b0;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         ce   = 1'b0;
  logic         head = 1'b0;
  logic         cm   = 1'b0;
  logic         tail, full, err;
  logic [N-1:0] cout;
  logic         tail1, full1, err1;
  logic [N-1:0] cout1;

  cfg_const_bank #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .RESET_VAL(1'b0)
  ) dut (
    .prog_clk(clk), .pReset(rst), .config_enable(ce),
    .ccff_head(head), .ccff_tail(tail), .commit(cm),
    .const_out(cout), .cfg_full(full), .cfg_err(err)
  );

  cfg_const_bank #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .RESET_VAL(1'b1)
  ) dut1 (
    .prog_clk(clk), .pReset(rst), .config_enable(1'b0),
    .ccff_head(1'b0), .ccff_tail(tail1), .commit(1'b0),
    .const_out(cout1), .cfg_full(full1), .cfg_err(err1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] c;
    logic         f;
    logic         e;
    logic         t;
  } exp_t;

  exp_t         sbq[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  bit           m_hist[$];
  int           m_cnt;
  logic [N-1:0] m_act;
  bit           m_err;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // m_hist[0] is the oldest bit in the chain, i.e. the shadow MSB
  function automatic exp_t model(bit r, bit e, bit h, bit c);
    exp_t x;
    bit   ok;
    bit   p;
    if (r) begin
      m_hist.delete();
      for (int i = 0; i < L; i++) m_hist.push_back(RV);
      m_cnt = 0;
      m_act = {N{RV}};
      m_err = 1'b0;
      x.t   = RV;
    end else begin
      x.t = m_hist[0];
      p = 1'b0;
      foreach (m_hist[i]) p ^= m_hist[i];
      ok = c && !e && (m_cnt == L) && (PAR == 0 || p == 1'b0);
      if (c && !ok) m_err = 1'b1;
      if (ok) begin
        for (int i = 0; i < N; i++) m_act[N-1-i] = m_hist[i];
        m_cnt = 0;
      end else if (e) begin
        m_hist.push_back(h);
        void'(m_hist.pop_front());
        if (m_cnt < L) m_cnt++;
      end
    end
    x.c = m_act;
    x.f = (m_cnt == L);
    x.e = m_err;
    return x;
  endfunction

  task automatic step(bit r, bit e, bit h, bit c);
    @(posedge clk);
    #3;
    rst  = r;
    ce   = e;
    head = h;
    cm   = c;
    sbq.push_back(model(r, e, h, c));
  endtask

  task automatic load(logic [N-1:0] d, bit pb);
    for (int i = N - 1; i >= 0; i--) step(0, 1, d[i], 0);
    if (PAR != 0) step(0, 1, pb, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      exp_t x;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("const_out", 32'(cout), 32'(x.c));
        chk("cfg_full", 32'(full), 32'(x.f));
        chk("cfg_err", 32'(err), 32'(x.e));
        chk("ccff_tail", 32'(tail), 32'(x.t));
      end
    end
  end

  initial begin
    logic [N-1:0] d;
    bit           pb;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(5);
    chk("rv1_const_out", 32'(cout1), 32'hFF);
    chk("rv1_cfg_full", 32'(full1), 32'h0);
    chk("rv1_cfg_err", 32'(err1), 32'h0);
    chk("rv1_ccff_tail", 32'(tail1), 32'h1);

    d = 8'hA5;
    load(d, ^d);
    step(0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 5; i++) step(0, 1, 1'(i), 0);
    step(0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    idle(2);

    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    d = 8'h3C;
    load(d, ^d);
    step(0, 0, 0, 1);
    idle(10);

    d = 8'h5A;
    load(d, ^d);
    step(0, 1, 1, 1);
    idle(1);
    step(0, 0, 0, 1);
    idle(2);

`ifdef CFG_CONST_BANK_PARITY_EN
    step(1, 0, 0, 0);
    idle(1);
    load(8'h01, 1'b1);
    step(0, 0, 0, 1);
    idle(1);
    load(8'h01, 1'b0);
    step(0, 0, 0, 1);
    idle(2);
`endif

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) step(1, 0, 0, 0);
      if ($urandom_range(0, 5) == 0) step(0, 0, 0, 1);
      repeat ($urandom_range(0, 3)) step(0, 1, 1'($urandom), 0);
      d  = N'($urandom);
      pb = (^d) ^ ($urandom_range(0, 7) == 0);
      load(d, pb);
      idle($urandom_range(0, 2));
      step(0, $urandom_range(0, 5) == 0, 1'($urandom), 1);
      idle($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
